ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_pkg.sv | 29 ++
 rtl/ram_arbiter_if.sv | 36 +++
 rtl/ram_arbiter_rr_arbiter2.sv | 31 +++
 rtl/ram_arbiter.sv | 70 +++++++
 tb/tb_ram_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter:
// requester indices, read-owner tag and the round-robin pick.
package ram_arbiter_pkg;

    localparam int REQ_CORE = 0;
    localparam int REQ_DBG  = 1;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    // last = index granted most recently; the other side wins a tie
    function automatic logic [1:0] rr_pick(
        input logic [1:0] req,
        input logic       last
    );
        logic [1:0] g;
        g = 2'b00;
        case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = last ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the data-RAM arbiter
// (core = 0, debug/loader = 1).
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  i_req_0;
    logic                  i_we_0;
    logic [ADDR_WIDTH-1:0] i_addr_0;
    logic [DATA_WIDTH-1:0] i_wdata_0;
    logic                  o_gnt_0;
    logic                  o_rvalid_0;
    logic [DATA_WIDTH-1:0] o_rdata_0;

    logic                  i_req_1;
    logic                  i_we_1;
    logic [ADDR_WIDTH-1:0] i_addr_1;
    logic [DATA_WIDTH-1:0] i_wdata_1;
    logic                  o_gnt_1;
    logic                  o_rvalid_1;
    logic [DATA_WIDTH-1:0] o_rdata_1;

    modport master (
        output i_req_0, i_we_0, i_addr_0, i_wdata_0,
        output i_req_1, i_we_1, i_addr_1, i_wdata_1,
        input  o_gnt_0, o_rvalid_0, o_rdata_0,
        input  o_gnt_1, o_rvalid_1, o_rdata_1
    );

    modport slave (
        input  i_req_0, i_we_0, i_addr_0, i_wdata_0,
        input  i_req_1, i_we_1, i_addr_1, i_wdata_1,
        output o_gnt_0, o_rvalid_0, o_rdata_0,
        output o_gnt_1, o_rvalid_1, o_rdata_1
    );
endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant
// from the request pair and a registered last-winner pointer.
module rr_arbiter2
    import ram_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic       r_last;
    logic [1:0] w_gnt;

    // no grant may escape while reset is held
    always_comb begin
        w_gnt = 2'b00;
        if (i_rst_n)
            w_gnt = rr_pick(i_req, r_last);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_last <= 1'b1;
        else if (|w_gnt)
            r_last <= w_gnt[REQ_DBG];
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the core and the
// debug port; routes the winner to the RAM and tags read returns.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ram_arbiter_if.slave          bus,
    output logic                  o_ram_load,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_sel;
    logic       w_rd;
    logic       r_rd_pend;
    owner_e     r_rd_owner;

    assign w_req = {bus.i_req_1, bus.i_req_0};

    rr_arbiter2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    assign w_sel = w_gnt[REQ_DBG];

    // idle cycles leave requester 0 on the address/data lines
    always_comb begin
        o_ram_addr = bus.i_addr_0;
        o_ram_data = bus.i_wdata_0;
        if (w_sel) begin
            o_ram_addr = bus.i_addr_1;
            o_ram_data = bus.i_wdata_1;
        end
    end

    assign o_ram_load = (w_gnt[REQ_CORE] & bus.i_we_0)
                      | (w_gnt[REQ_DBG]  & bus.i_we_1);

    assign w_rd = (w_gnt[REQ_CORE] & ~bus.i_we_0)
                | (w_gnt[REQ_DBG]  & ~bus.i_we_1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= OWN_CORE;
        end else begin
            r_rd_pend <= w_rd;
            if (w_rd)
                r_rd_owner <= w_sel ? OWN_DBG : OWN_CORE;
        end
    end

    assign bus.o_gnt_0    = w_gnt[REQ_CORE];
    assign bus.o_gnt_1    = w_gnt[REQ_DBG];
    assign bus.o_rvalid_0 = r_rd_pend && (r_rd_owner == OWN_CORE);
    assign bus.o_rvalid_1 = r_rd_pend && (r_rd_owner == OWN_DBG);
    assign bus.o_rdata_0  = i_ram_data;
    assign bus.o_rdata_1  = i_ram_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, shadow memory and a
// scoreboard of expected read returns (owner, data, cycle).
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    typedef struct {
        int          owner;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_load;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] mem    [256];
    logic [15:0] shadow [256];
    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          exp_last = 1;

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus();

    ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus.slave),
        .o_ram_load (ram_load),
        .o_ram_addr (ram_addr),
        .o_ram_data (ram_wdata),
        .i_ram_data (ram_rdata)
    );

    // single-port RAM, registered read
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_load) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin : mon
        exp_t e;
        int   own;
        logic [15:0] d;
        if (bus.o_rvalid_0 || bus.o_rvalid_1) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL rvalid_unexpected: rvalid0=%b rvalid1=%b at cyc %0d, required none",
                         bus.o_rvalid_0, bus.o_rvalid_1, cyc);
            end else begin
                e = q.pop_front();
                own = bus.o_rvalid_1 ? 1 : 0;
                d = own ? bus.o_rdata_1 : bus.o_rdata_0;
                if ((bus.o_rvalid_0 && bus.o_rvalid_1) || own != e.owner
                    || d !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL rvalid_return: owner=%0d data=%h cyc=%0d both=%b, required owner=%0d data=%h cyc=%0d",
                             own, d, cyc, bus.o_rvalid_0 && bus.o_rvalid_1,
                             e.owner, e.data, e.cyc);
                end
            end
        end
        if (q.size() != 0 && q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rvalid_missing: no pulse at cyc %0d, required owner=%0d data=%h",
                     q[0].cyc, q[0].owner, q[0].data);
            void'(q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int n, input logic req, input logic we,
                       input logic [7:0] a, input logic [15:0] d);
        if (n == 0) begin
            bus.i_req_0 = req; bus.i_we_0 = we;
            bus.i_addr_0 = a;  bus.i_wdata_0 = d;
        end else begin
            bus.i_req_1 = req; bus.i_we_1 = we;
            bus.i_addr_1 = a;  bus.i_wdata_1 = d;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drv(0, 1'b1, 1'b0, 8'h01, 16'h0);
        drv(1, 1'b1, 1'b1, 8'h02, 16'hDEAD);
        @(negedge clk);
        n_tests++; if (bus.o_gnt_0 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0: got %b, required 0", bus.o_gnt_0); end
        n_tests++; if (bus.o_gnt_1 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt1: got %b, required 0", bus.o_gnt_1); end
        n_tests++; if (ram_load !== 1'b0) begin n_fail++; $display("FAIL rst_load: got %b, required 0", ram_load); end
        n_tests++; if (bus.o_rvalid_0 !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid0: got %b, required 0", bus.o_rvalid_0); end
        n_tests++; if (bus.o_rvalid_1 !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid1: got %b, required 0", bus.o_rvalid_1); end
        step();
        rst_n = 1'b1;
        drv(1, 1'b1, 1'b0, 8'h02, 16'h0);
        @(negedge clk);
        n_tests++; if (bus.o_gnt_0 !== 1'b1 || bus.o_gnt_1 !== 1'b0) begin n_fail++; $display("FAIL rst_first_tie: gnt=%b%b, required 01", bus.o_gnt_1, bus.o_gnt_0); end
        q.push_back('{0, shadow[8'h01], cyc + 1});
        exp_last = 0;
        step();
        drv(0, 1'b0, 1'b0, 8'h00, 16'h0);
        drv(1, 1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
    endtask

    task automatic test_core_only();
        step();
        drv(0, 1'b1, 1'b1, 8'h10, 16'hBEEF);
        @(negedge clk);
        n_tests++; if (bus.o_gnt_0 !== 1'b1 || bus.o_gnt_1 !== 1'b0) begin n_fail++; $display("FAIL core_wr_gnt: gnt=%b%b, required 01", bus.o_gnt_1, bus.o_gnt_0); end
        n_tests++; if (ram_load !== 1'b1) begin n_fail++; $display("FAIL core_wr_load: got %b, required 1", ram_load); end
        n_tests++; if (ram_addr !== 8'h10 || ram_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL core_wr_bus: addr=%h data=%h, required 10 beef", ram_addr, ram_wdata); end
        shadow[8'h10] = 16'hBEEF;
        exp_last = 0;
        step();
        drv(0, 1'b1, 1'b0, 8'h10, 16'h0);
        @(negedge clk);
        n_tests++; if (bus.o_gnt_0 !== 1'b1 || ram_load !== 1'b0) begin n_fail++; $display("FAIL core_rd_gnt: gnt0=%b load=%b, required 1 0", bus.o_gnt_0, ram_load); end
        q.push_back('{0, shadow[8'h10], cyc + 1});
        step();
        drv(0, 1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
        n_tests++; if (bus.o_gnt_0 !== 1'b0 || ram_load !== 1'b0) begin n_fail++; $display("FAIL core_idle: gnt0=%b load=%b, required 0 0", bus.o_gnt_0, ram_load); end
    endtask

    task automatic test_contention();
        int w;
        step();
        drv(0, 1'b1, 1'b0, 8'h01, 16'h0);
        drv(1, 1'b1, 1'b0, 8'h02, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            w = (exp_last == 1) ? 0 : 1;
            n_tests++;
            if (bus.o_gnt_0 !== (w == 0) || bus.o_gnt_1 !== (w == 1)
                || ram_addr !== (w ? 8'h02 : 8'h01)) begin
                n_fail++;
                $display("FAIL contention_%0d: gnt=%b%b addr=%h, required winner %0d", i, bus.o_gnt_1, bus.o_gnt_0, ram_addr, w);
            end
            q.push_back('{w, shadow[w ? 8'h02 : 8'h01], cyc + 1});
            exp_last = w;
            step();
        end
        drv(0, 1'b0, 1'b0, 8'h00, 16'h0);
        drv(1, 1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
    endtask

    task automatic test_raw();
        step();
        drv(1, 1'b1, 1'b1, 8'h20, 16'h5A5A);
        @(negedge clk);
        n_tests++; if (bus.o_gnt_1 !== 1'b1 || ram_load !== 1'b1 || ram_addr !== 8'h20 || ram_wdata !== 16'h5A5A) begin n_fail++; $display("FAIL raw_dbg_wr: gnt1=%b load=%b addr=%h data=%h, required 1 1 20 5a5a", bus.o_gnt_1, ram_load, ram_addr, ram_wdata); end
        shadow[8'h20] = 16'h5A5A;
        exp_last = 1;
        step();
        drv(1, 1'b0, 1'b0, 8'h00, 16'h0);
        drv(0, 1'b1, 1'b0, 8'h20, 16'h0);
        @(negedge clk);
        n_tests++; if (bus.o_gnt_0 !== 1'b1 || ram_addr !== 8'h20) begin n_fail++; $display("FAIL raw_core_rd: gnt0=%b addr=%h, required 1 20", bus.o_gnt_0, ram_addr); end
        q.push_back('{0, shadow[8'h20], cyc + 1});
        exp_last = 0;
        step();
        drv(0, 1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
    endtask

    task automatic test_held();
        int w;
        bit dbg_pend;
        int waited;
        step();
        drv(1, 1'b1, 1'b1, 8'h31, 16'h7777);
        @(negedge clk);
        n_tests++; if (bus.o_gnt_1 !== 1'b1 || ram_load !== 1'b1) begin n_fail++; $display("FAIL held_pre_wr: gnt1=%b load=%b, required 1 1", bus.o_gnt_1, ram_load); end
        shadow[8'h31] = 16'h7777;
        exp_last = 1;
        step();
        drv(0, 1'b1, 1'b0, 8'h05, 16'hC00C);
        drv(1, 1'b1, 1'b0, 8'h30, 16'hD00D);
        dbg_pend = 1'b1;
        waited = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            w = dbg_pend ? ((exp_last == 1) ? 0 : 1) : 0;
            n_tests++;
            if (bus.o_gnt_0 !== (w == 0) || bus.o_gnt_1 !== (w == 1)
                || ram_addr !== (w ? 8'h30 : 8'h05)
                || ram_wdata !== (w ? 16'hD00D : 16'hC00C)) begin
                n_fail++;
                $display("FAIL held_%0d: gnt=%b%b addr=%h data=%h, required winner %0d", i, bus.o_gnt_1, bus.o_gnt_0, ram_addr, ram_wdata, w);
            end
            q.push_back('{w, shadow[w ? 8'h30 : 8'h05], cyc + 1});
            exp_last = w;
            if (w == 1) dbg_pend = 1'b0;
            else if (dbg_pend) waited++;
            step();
            if (!dbg_pend) drv(1, 1'b0, 1'b0, 8'h00, 16'h0);
        end
        n_tests++; if (dbg_pend || waited > 1) begin n_fail++; $display("FAIL held_wait: pending=%b waited=%0d, required 0 <=1", dbg_pend, waited); end
        drv(0, 1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        step();
        drv(1, 1'b1, 1'b1, 8'h40, 16'h1234);
        @(negedge clk);
        shadow[8'h40] = 16'h1234;
        exp_last = 1;
        step();
        drv(1, 1'b0, 1'b0, 8'h00, 16'h0);
        drv(0, 1'b1, 1'b0, 8'h01, 16'h0);
        @(negedge clk);
        n_tests++; if (bus.o_gnt_0 !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt: got %b, required 1", bus.o_gnt_0); end
        exp_last = 0;
        step();
        rst_n = 1'b0;
        drv(0, 1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
        n_tests++; if (bus.o_rvalid_0 !== 1'b0 || bus.o_rvalid_1 !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid: got %b%b, required 00", bus.o_rvalid_1, bus.o_rvalid_0); end
        step();
        rst_n = 1'b1;
        drv(0, 1'b1, 1'b0, 8'h01, 16'h0);
        drv(1, 1'b1, 1'b0, 8'h02, 16'h0);
        @(negedge clk);
        n_tests++; if (bus.o_gnt_0 !== 1'b1 || bus.o_gnt_1 !== 1'b0) begin n_fail++; $display("FAIL midrst_last: gnt=%b%b, required 01", bus.o_gnt_1, bus.o_gnt_0); end
        q.push_back('{0, shadow[8'h01], cyc + 1});
        exp_last = 0;
        step();
        drv(0, 1'b0, 1'b0, 8'h00, 16'h0);
        drv(1, 1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'(i * 16'h1111);
            shadow[i] = 16'(i * 16'h1111);
        end
        drv(0, 1'b0, 1'b0, 8'h00, 16'h0);
        drv(1, 1'b0, 1'b0, 8'h00, 16'h0);
        test_reset();
        test_core_only();
        test_contention();
        test_raw();
        test_held();
        test_reset_mid_read();
        step();
        @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d returns outstanding, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
